mavg_multi: RTL and testbench

Multi-channel, time-multiplexed moving-average low-pass filter: the parametrised successor to the single-channel 15-bit, 512-tap boxcar filter on the glove sensor path. A single instance serves all sensor axes. Each channel keeps its own circular delay line in one shared RAM and its own running accumulator, so one adder serves every channel. It sits between the sensor sample demultiplexer and the gesture logic, and adds a valid handshake, per-channel tagging and a window-primed flag.

---
 rtl/mavg_multi.sv | 118 +++++++++++
 tb/tb_mavg_multi.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mavg_multi.sv
// Multi-channel time-multiplexed moving-average (boxcar) filter, N = 2^LOG2N taps per channel.
// Optional round-half-up output when MAVG_ROUND_EN is defined; plain truncation otherwise.
module mavg_multi #(
  parameter int WIDTH    = 15,
  parameter int LOG2N    = 9,
  parameter int CHANNELS = 3,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clock_in,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [CW-1:0]           in_chan,
  input  logic signed [WIDTH-1:0] signal_in,
  output logic                    out_valid,
  output logic [CW-1:0]           out_chan,
  output logic signed [WIDTH-1:0] signal_out,
  output logic                    out_primed
);

  localparam int AW    = WIDTH + LOG2N;
  localparam int DEPTH = CHANNELS << LOG2N;
  localparam int ABITS = CW + LOG2N;

  localparam logic [CW:0]    CH_LIM  = (CW+1)'(CHANNELS);
  localparam logic [LOG2N:0] FILL_N  = {1'b1, {LOG2N{1'b0}}};
  localparam logic [LOG2N:0] FILL_N1 = {1'b0, {LOG2N{1'b1}}};

  logic [WIDTH-1:0]     mem  [DEPTH];
  logic [LOG2N-1:0]     ptr  [CHANNELS];
  logic [LOG2N:0]       fill [CHANNELS];
  logic signed [AW-1:0] acc  [CHANNELS];

  logic                    accept;
  logic [ABITS-1:0]        rd_addr;
  logic [WIDTH-1:0]        rd_data;

  logic                    s1_valid;
  logic                    s1_full;
  logic                    s1_primed;
  logic [CW-1:0]           s1_chan;
  logic signed [WIDTH-1:0] s1_sample;
  logic [ABITS-1:0]        s1_addr;

  logic signed [AW-1:0]    new_ext;
  logic signed [AW-1:0]    old_ext;
  logic signed [AW-1:0]    acc_next;
  logic signed [AW-1:0]    acc_adj;
  logic signed [AW-1:0]    acc_shr;

  assign accept  = in_valid && ({1'b0, in_chan} < CH_LIM);
  assign rd_addr = {in_chan, ptr[in_chan]};

  // Delay-line RAM: synchronous read in stage 0, write of the new sample in stage 1.
  always_ff @(posedge clock_in) begin
    if (accept) begin
      rd_data <= mem[rd_addr];
    end
    if (s1_valid && !reset) begin
      mem[s1_addr] <= s1_sample;
    end
  end

  // acc is read and written in stage 1 only, so a back-to-back sample on the
  // same channel already sees the updated register without a bypass.
  always_comb begin
    new_ext  = {{LOG2N{s1_sample[WIDTH-1]}}, s1_sample};
    old_ext  = s1_full ? {{LOG2N{rd_data[WIDTH-1]}}, rd_data} : '0;
    acc_next = acc[s1_chan] + new_ext - old_ext;
`ifdef MAVG_ROUND_EN
    acc_adj  = acc_next + (AW'(1) << (LOG2N - 1));
`else
    acc_adj  = acc_next;
`endif
    acc_shr  = acc_adj >>> LOG2N;
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        ptr[i]  <= '0;
        fill[i] <= '0;
        acc[i]  <= '0;
      end
      s1_valid   <= 1'b0;
      s1_full    <= 1'b0;
      s1_primed  <= 1'b0;
      s1_chan    <= '0;
      s1_sample  <= '0;
      s1_addr    <= '0;
      out_valid  <= 1'b0;
      out_chan   <= '0;
      signal_out <= '0;
      out_primed <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_chan      <= in_chan;
        s1_sample    <= signal_in;
        s1_addr      <= rd_addr;
        s1_full      <= (fill[in_chan] == FILL_N);
        s1_primed    <= (fill[in_chan] == FILL_N) || (fill[in_chan] == FILL_N1);
        ptr[in_chan] <= ptr[in_chan] + 1'b1;
        if (fill[in_chan] != FILL_N) begin
          fill[in_chan] <= fill[in_chan] + 1'b1;
        end
      end

      out_valid <= s1_valid;
      if (s1_valid) begin
        acc[s1_chan] <= acc_next;
        out_chan     <= s1_chan;
        signal_out   <= acc_shr[WIDTH-1:0];
        out_primed   <= s1_primed;
      end
    end
  end

endmodule

// File: tb/tb_mavg_multi.sv
// Directed self-checking bench for mavg_multi with WIDTH=15, N=4, three channels.
// Expected values are hand-computed; MAVG_ROUND_EN selects the rounded expectations.
module tb_mavg_multi;

  logic               clock_in = 1'b0;
  logic               reset;
  logic               in_valid;
  logic [1:0]         in_chan;
  logic signed [14:0] signal_in;
  logic               out_valid;
  logic [1:0]         out_chan;
  logic signed [14:0] signal_out;
  logic               out_primed;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0;

  int q_data[$];
  int q_chan[$];
  int q_prim[$];
  int q_cyc[$];

  int s1_exp[6]  = '{25, 50, 75, 100, 100, 100};
  int s2_ch0[4]  = '{325, 550, 775, 1000};
  int s2_ch1[4]  = '{-250, -500, -750, -1000};
  int s4_exp[5]  = '{25, 50, 75, 100, 100};
  int ramp[4]    = '{25, 50, 75, 100};
`ifdef MAVG_ROUND_EN
  int s3_exp[12] = '{0, 0, 0, 0, 4096, 8192, 12287, 16383, 8191, 0, -8192, -16384};
  int s6_exp[4]  = '{0, 1, 1, 1};
`else
  int s3_exp[12] = '{0, 0, 0, 0, 4095, 8191, 12287, 16383, 8191, -1, -8193, -16384};
  int s6_exp[4]  = '{0, 0, 0, 0};
`endif

  mavg_multi #(
    .WIDTH   (15),
    .LOG2N   (2),
    .CHANNELS(3)
  ) dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_chan   (in_chan),
    .signal_in (signal_in),
    .out_valid (out_valid),
    .out_chan  (out_chan),
    .signal_out(signal_out),
    .out_primed(out_primed)
  );

  always #5 clock_in = ~clock_in;

  always @(posedge clock_in) cyc <= cyc + 1;

  always @(negedge clock_in) begin
    if (out_valid) begin
      q_data.push_back(int'(signal_out));
      q_chan.push_back(int'(out_chan));
      q_prim.push_back(int'(out_primed));
      q_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pop_check(input string tag, input int ch, input int d, input int pr);
    int gd, gc, gp, gt;
    if (q_data.size() == 0) begin
      check({tag, "_present"}, 0, 1);
    end else begin
      gd = q_data.pop_front();
      gc = q_chan.pop_front();
      gp = q_prim.pop_front();
      gt = q_cyc.pop_front();
      check({tag, "_chan"}, gc, ch);
      check({tag, "_data"}, gd, d);
      check({tag, "_prim"}, gp, pr);
    end
  endtask

  task automatic drive(input logic v, input int ch, input int d);
    in_valid  = v;
    in_chan   = ch[1:0];
    signal_in = d[14:0];
    @(posedge clock_in);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clock_in);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_vld"},  int'(out_valid), 0);
    check({tag, "_chan"}, int'(out_chan), 0);
    check({tag, "_data"}, int'(signal_out), 0);
    check({tag, "_prim"}, int'(out_primed), 0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_chan   = '0;
    signal_in = '0;
    repeat (2) @(posedge clock_in);
    #1;
    check_zero_outputs("rst");
    reset = 1'b0;

    // constant 100 on channel 0: ramp, latency, primed flag
    t0 = cyc;
    for (int i = 0; i < 6; i++) drive(1'b1, 0, 100);
    idle(3);
    check("lat_first", (q_cyc.size() > 0) ? q_cyc[0] - t0 : -1, 2);
    check("lat_stream", (q_cyc.size() > 5) ? q_cyc[5] - q_cyc[0] : -1, 5);
    for (int i = 0; i < 6; i++) pop_check("const", 0, s1_exp[i], (i >= 3) ? 1 : 0);
    check("const_extra", q_data.size(), 0);
    check("hold_data", int'(signal_out), 100);
    check("hold_vld", int'(out_valid), 0);
    check("hold_prim", int'(out_primed), 1);

    // interleaved channels converge independently
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 0, 1000);
      drive(1'b1, 1, -1000);
    end
    idle(3);
    for (int i = 0; i < 4; i++) begin
      pop_check("ilv0", 0, s2_ch0[i], 1);
      pop_check("ilv1", 1, s2_ch1[i], (i == 3) ? 1 : 0);
    end
    check("ilv_extra", q_data.size(), 0);

    // full-scale steps on channel 2
    for (int i = 0; i < 4; i++) drive(1'b1, 2, 0);
    for (int i = 0; i < 4; i++) drive(1'b1, 2, 16383);
    for (int i = 0; i < 4; i++) drive(1'b1, 2, -16384);
    idle(3);
    for (int i = 0; i < 12; i++) pop_check("step", 2, s3_exp[i], (i >= 3) ? 1 : 0);
    check("step_extra", q_data.size(), 0);

    // out-of-range channel is dropped
    do_reset();
    drive(1'b1, 0, 100);
    drive(1'b1, 3, 7777);
    drive(1'b1, 0, 100);
    drive(1'b1, 3, -5);
    drive(1'b1, 0, 100);
    drive(1'b1, 0, 100);
    drive(1'b1, 3, 0);
    drive(1'b1, 0, 100);
    idle(3);
    check("drop_count", q_data.size(), 5);
    for (int i = 0; i < 5; i++) pop_check("drop", 0, s4_exp[i], (i >= 3) ? 1 : 0);

    // reset with a sample in flight and a sample offered during reset
    drive(1'b1, 0, 100);
    in_valid  = 1'b1;
    in_chan   = 2'd0;
    signal_in = 15'sd100;
    reset     = 1'b1;
    @(posedge clock_in);
    #1;
    reset = 1'b0;
    idle(3);
    check("flight_outs", q_data.size(), 0);
    check_zero_outputs("flight");
    for (int i = 0; i < 4; i++) drive(1'b1, 0, 100);
    idle(3);
    for (int i = 0; i < 4; i++) pop_check("restart", 0, ramp[i], (i == 3) ? 1 : 0);
    check("restart_extra", q_data.size(), 0);

    // small values: truncation versus rounding
    do_reset();
    drive(1'b1, 0, 1);
    drive(1'b1, 0, 1);
    drive(1'b1, 0, 0);
    drive(1'b1, 0, 0);
    idle(3);
    for (int i = 0; i < 4; i++) pop_check("round", 0, s6_exp[i], (i == 3) ? 1 : 0);
    check("round_extra", q_data.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
